// File: rtl/qq_pkg.sv
// -----------------------------------------------------------------------------
// qq_pkg
// Shared definitions for the QuickQ RAM-backed sorted priority queue:
//   - deq_state_t : one-hot state encoding of the removal-side controller
//   - QQ_DATA_W   : default entry width shared by insert and dequeue sides
//   - QQ_DEPTH    : default number of RAM entries (power of two, >= 2)
//   - qq_cnt_w()  : width of an occupancy count able to hold 0..depth
// -----------------------------------------------------------------------------
package qq_pkg;

    localparam int QQ_DATA_W = 16;
    localparam int QQ_DEPTH  = 16;

    typedef enum logic [4:0] {
        IDLE     = 5'b00001,
        HEAD     = 5'b00010,
        SHIFT_RD = 5'b00100,
        SHIFT_WR = 5'b01000,
        DONE     = 5'b10000
    } deq_state_t;

    // A full queue holds depth entries, so the count needs one more code
    // than the address range.
    function automatic int qq_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/qq_addr_counter.sv
// -----------------------------------------------------------------------------
// qq_addr_counter
// Loadable address up-counter. Used as the shift index of the dequeue
// controller and as the address-advance counter of the insert side.
// Load has priority over increment.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset, clears q
//   ld      in   load ld_val into the counter
//   ld_val  in   value to load
//   incr    in   increment by one (ignored while ld is high)
//   q       out  current count
// -----------------------------------------------------------------------------
module qq_addr_counter #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [ADDR_W-1:0] ld_val,
    input  logic              incr,
    output logic [ADDR_W-1:0] q
);

    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] count_d;

    always_comb begin
        // NOTE: default first so every path assigns count_d; otherwise a latch is inferred.
        count_d = count_q;
        if (ld) begin
            count_d = ld_val;
        end else if (incr) begin
            count_d = count_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q = count_q;

endmodule

// File: rtl/qq_dequeue_ctrl.sv
// -----------------------------------------------------------------------------
// qq_dequeue_ctrl
// Removal-side controller of the QuickQ sorted priority queue. On an accepted
// request it reads the head entry (address 0), returns it on out_data, then
// shifts entries 1..cnt_lat-1 down by one address and pulses count_decr.
// The vacated top slot is left stale; the decremented count marks it empty.
//
// Optional feature (macro QQ_DEQ_UNDERFLOW_EN): adds a sticky 'underflow'
// output, set the cycle after a request is seen in IDLE with count == 0 and
// cleared only by rst.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   count       in   queue occupancy, owned by the queue top
//   deq_req     in   dequeue request, accepted when deq_req && deq_ready
//   deq_ready   out  high only in IDLE
//   busy        out  high outside IDLE; insert side must hold off
//   out_valid   out  one-cycle pulse, out_data valid
//   out_data    out  registered head entry, held until next capture
//   count_decr  out  one-cycle pulse coincident with out_valid
//   ram_addr    out  RAM address
//   ram_we      out  RAM write enable (SHIFT_WR only)
//   ram_wdata   out  RAM write data
//   ram_rdata   in   RAM read data, one-cycle synchronous read latency
//   underflow   out  (QQ_DEQ_UNDERFLOW_EN only) sticky empty-dequeue flag
// -----------------------------------------------------------------------------
module qq_dequeue_ctrl
    import qq_pkg::*;
#(
    parameter int DATA_W = QQ_DATA_W,
    parameter int DEPTH  = QQ_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = qq_cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  count,
    input  logic              deq_req,
    output logic              deq_ready,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              count_decr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef QQ_DEQ_UNDERFLOW_EN
    ,
    output logic              underflow
`endif
);

    deq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_lat_q, cnt_lat_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              idx_ld;
    logic [ADDR_W-1:0] idx_ld_val;
    logic              idx_incr;
    logic [ADDR_W-1:0] idx_q;

    qq_addr_counter #(.ADDR_W(ADDR_W)) u_idx (
        .clk    (clk),
        .rst    (rst),
        .ld     (idx_ld),
        .ld_val (idx_ld_val),
        .incr   (idx_incr),
        .q      (idx_q)
    );

    always_comb begin
        state_d    = state_q;
        cnt_lat_d  = cnt_lat_q;
        out_data_d = out_data_q;
        idx_ld     = 1'b0;
        idx_ld_val = '0;
        idx_incr   = 1'b0;
        ram_addr   = '0;
        ram_we     = 1'b0;
        ram_wdata  = '0;
        out_valid  = 1'b0;
        count_decr = 1'b0;

        unique case (state_q)
            IDLE: begin
                // ram_addr stays 0 so the head read is already under way
                // in the acceptance cycle.
                if (deq_req && (count != '0)) begin
                    cnt_lat_d = count;
                    state_d   = HEAD;
                end
            end
            HEAD: begin
                out_data_d = ram_rdata;
                if (cnt_lat_q == CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    idx_ld     = 1'b1;
                    idx_ld_val = ADDR_W'(1);
                    state_d    = SHIFT_RD;
                end
            end
            SHIFT_RD: begin
                ram_addr = idx_q;
                state_d  = SHIFT_WR;
            end
            SHIFT_WR: begin
                // ram_rdata holds the entry read at idx in SHIFT_RD.
                ram_we    = 1'b1;
                ram_addr  = idx_q - ADDR_W'(1);
                ram_wdata = ram_rdata;
                if (CNT_W'(idx_q) == (cnt_lat_q - CNT_W'(1))) begin
                    state_d = DONE;
                end else begin
                    idx_incr = 1'b1;
                    state_d  = SHIFT_RD;
                end
            end
            DONE: begin
                out_valid  = 1'b1;
                count_decr = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_lat_q  <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_lat_q  <= cnt_lat_d;
            out_data_q <= out_data_d;
        end
    end

    assign deq_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;

`ifdef QQ_DEQ_UNDERFLOW_EN
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_q <= 1'b0;
        end else if ((state_q == IDLE) && deq_req && (count == '0)) begin
            underflow_q <= 1'b1;
        end
    end

    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_qq_dequeue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_qq_dequeue_ctrl
// Self-checking bench for qq_dequeue_ctrl with a behavioural single-port RAM.
// Expected RAM writes and dequeued entries (with their arrival cycle) are
// pushed to scoreboard queues when a request is driven; a negedge monitor pops
// and compares them as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_qq_dequeue_ctrl;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CNT_W-1:0]  count = '0;
    logic              deq_req = 1'b0;
    logic              deq_ready;
    logic              busy;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              count_decr;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
`ifdef QQ_DEQ_UNDERFLOW_EN
    logic              underflow;
`endif

    qq_dequeue_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .count      (count),
        .deq_req    (deq_req),
        .deq_ready  (deq_ready),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .count_decr (count_decr),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
`ifdef QQ_DEQ_UNDERFLOW_EN
        ,
        .underflow  (underflow)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- RAM model with a bench-side preload port ----------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic              pl_en   = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [DATA_W-1:0] pl_data = '0;

    // NOTE: the array is not reset, as in the real RAM; tests preload what they read.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               exp_wr_q[$];
    logic [DATA_W-1:0] exp_out_data_q[$];
    int unsigned       exp_out_cyc_q[$];
    int                done_cnt = 0;
    int                max_addr = 0;
    wr_t               mon_w;

    always @(negedge clk) begin
        if (busy && (int'(ram_addr) > max_addr)) max_addr = int'(ram_addr);
        if (ram_we) begin
            if (exp_wr_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_w = exp_wr_q.pop_front();
                check("wr_addr", 32'(ram_addr), 32'(mon_w.addr));
                check("wr_data", 32'(ram_wdata), 32'(mon_w.data));
            end
        end
        if (out_valid || count_decr) begin
            check("decr_with_valid", 32'(count_decr), 32'(out_valid));
            if (exp_out_data_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("out_data", 32'(out_data), 32'(exp_out_data_q.pop_front()));
                check("out_cycle", cyc, exp_out_cyc_q.pop_front());
            end
            done_cnt++;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        int                cnt;
        logic [DATA_W-1:0] d [DEPTH];
        logic [DATA_W-1:0] exp_data;
        int                exp_lat;
        int                chg_cyc;   // 0: count held constant
        int                chg_val;
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs [NVEC];

    task automatic load_word(input int a, input logic [DATA_W-1:0] v);
        pl_en   = 1'b1;
        pl_addr = ADDR_W'(a);
        pl_data = v;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic run_vec(input int n);
        int  c;
        int  start;
        wr_t w;
        c = vecs[n].cnt;
        for (int i = 0; i < DEPTH; i++) load_word(i, vecs[n].d[i]);
        check("idle_ready", 32'(deq_ready), 1);
        check("idle_busy", 32'(busy), 0);
        max_addr = 0;
        start    = done_cnt;
        for (int i = 1; i < c; i++) begin
            w.addr = ADDR_W'(i - 1);
            w.data = vecs[n].d[i];
            exp_wr_q.push_back(w);
        end
        exp_out_data_q.push_back(vecs[n].exp_data);
        exp_out_cyc_q.push_back(cyc + 32'(vecs[n].exp_lat));
        count   = CNT_W'(c);
        deq_req = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                deq_req = 1'b0;
                check("accept_busy", 32'(busy), 1);
                check("accept_ready", 32'(deq_ready), 0);
            end
            if (k == vecs[n].chg_cyc) count = CNT_W'(vecs[n].chg_val);
            if (done_cnt != start) break;
        end
        if (done_cnt == start) check("timeout_out_valid", 0, 1);
        count = CNT_W'(c - 1);
        @(posedge clk);
        #1;
        check("back_to_idle", 32'(deq_ready), 1);
        check("pending_writes", 32'(exp_wr_q.size()), 0);
        for (int i = 0; i + 1 < c; i++) check("shifted_entry", 32'(mem[i]), 32'(vecs[n].d[i + 1]));
        check("stale_slot", 32'(mem[c - 1]), 32'(vecs[n].d[c - 1]));
        check("max_addr", 32'(max_addr), 32'(c - 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int start;

        // -------- table fill --------
        for (int n = 0; n < NVEC; n++) begin
            for (int i = 0; i < DEPTH; i++) vecs[n].d[i] = DATA_W'(32'hD000 + i);
            vecs[n].chg_cyc = 0;
            vecs[n].chg_val = 0;
        end
        vecs[0].cnt = 1;  vecs[0].d[0] = 16'h0042; vecs[0].exp_data = 16'h0042; vecs[0].exp_lat = 2;
        vecs[1].cnt = 4;  vecs[1].d[0] = 16'd5;  vecs[1].d[1] = 16'd9; vecs[1].d[2] = 16'd12; vecs[1].d[3] = 16'd30;
        vecs[1].exp_data = 16'd5; vecs[1].exp_lat = 8;
        vecs[2].cnt = 16;
        for (int i = 0; i < DEPTH; i++) vecs[2].d[i] = DATA_W'(i + 1);
        vecs[2].exp_data = 16'd1; vecs[2].exp_lat = 32;
        vecs[3].cnt = 2;  vecs[3].d[0] = 16'hFFFF; vecs[3].d[1] = 16'h0000; vecs[3].exp_data = 16'hFFFF; vecs[3].exp_lat = 4;
        vecs[4].cnt = 3;  vecs[4].d[0] = 16'h1234; vecs[4].d[1] = 16'hABCD; vecs[4].d[2] = 16'h8000;
        vecs[4].exp_data = 16'h1234; vecs[4].exp_lat = 6;
        vecs[5].cnt = 4;  vecs[5].d[0] = 16'd5;  vecs[5].d[1] = 16'd9; vecs[5].d[2] = 16'd12; vecs[5].d[3] = 16'd30;
        vecs[5].exp_data = 16'd5; vecs[5].exp_lat = 8; vecs[5].chg_cyc = 3; vecs[5].chg_val = 7;

        // -------- reset values --------
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(deq_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_count_decr", 32'(count_decr), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_wdata", 32'(ram_wdata), 0);
        check("rst_out_data", 32'(out_data), 0);
`ifdef QQ_DEQ_UNDERFLOW_EN
        check("rst_underflow", 32'(underflow), 0);
`endif
        rst = 1'b0;

        // -------- empty dequeue --------
        start   = done_cnt;
        count   = '0;
        deq_req = 1'b1;
        @(posedge clk);
        #1;
        deq_req = 1'b0;
        check("empty_ready", 32'(deq_ready), 1);
        check("empty_busy", 32'(busy), 0);
`ifdef QQ_DEQ_UNDERFLOW_EN
        check("underflow_set", 32'(underflow), 1);
`endif
        repeat (4) @(posedge clk);
        #1;
        check("empty_no_out", 32'(done_cnt), 32'(start));
        check("empty_still_idle", 32'(deq_ready), 1);
`ifdef QQ_DEQ_UNDERFLOW_EN
        check("underflow_sticky", 32'(underflow), 1);
`endif

        // -------- table-driven dequeues --------
        for (int n = 0; n < NVEC; n++) run_vec(n);

        // -------- deq_req held high: re-accepted only after IDLE --------
        load_word(0, 16'h0077);
        start = done_cnt;
        exp_out_data_q.push_back(16'h0077);
        exp_out_cyc_q.push_back(cyc + 2);
        exp_out_data_q.push_back(16'h0077);
        exp_out_cyc_q.push_back(cyc + 5);
        count   = CNT_W'(1);
        deq_req = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        deq_req = 1'b0;
        for (int k = 0; k < 20 && done_cnt != start + 2; k++) begin
            @(posedge clk);
            #1;
        end
        check("held_req_two_outs", 32'(done_cnt - start), 2);
        check("held_req_queue_empty", 32'(exp_out_data_q.size()), 0);

        // -------- reset in the middle of a shift --------
        for (int i = 0; i < DEPTH; i++) load_word(i, DATA_W'(32'h0100 + i));
        start = done_cnt;
        mon_w.addr = 4'd0; mon_w.data = 16'h0101; exp_wr_q.push_back(mon_w);
        mon_w.addr = 4'd1; mon_w.data = 16'h0102; exp_wr_q.push_back(mon_w);
        count   = CNT_W'(8);
        deq_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) deq_req = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready", 32'(deq_ready), 1);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ram_we", 32'(ram_we), 0);
        check("midrst_ram_addr", 32'(ram_addr), 0);
        check("midrst_out_data", 32'(out_data), 0);
`ifdef QQ_DEQ_UNDERFLOW_EN
        check("midrst_underflow_clr", 32'(underflow), 0);
`endif
        count = '0;
        rst   = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_out", 32'(done_cnt), 32'(start));
        check("midrst_writes", 32'(exp_wr_q.size()), 0);
        check("midrst_idle", 32'(deq_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
